// File: rtl/ai_mc_burst_sched.sv
// Multi-channel burst scheduler: round-robin command arbitration, sub-burst
// splitting toward the PHY, beat streaming to/from the data FIFOs, sticky errors.
//
// state | meaning
// IDLE  | arbitrate command channels, accept one command
// SETUP | phy_start pulse is out, per-burst counters cleared
// XFER  | move beats, track phy_done, run watchdog and protocol checks
// NEXT  | advance address/remainder, then finish or start next sub-burst
module ai_mc_burst_sched #(
  parameter  int NCH        = 2,
  parameter  int ADDR_W     = 32,
  parameter  int LEN_W      = 16,
  parameter  int DATA_W     = 32,
  parameter  int MAX_BURST  = 16,
  parameter  int TIMEOUT    = 1023,
  localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int BEAT_BYTES = DATA_W / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        cmd_valid,
  output logic [NCH-1:0]        cmd_ready,
  input  logic [NCH-1:0]        cmd_wr,
  input  logic [NCH*ADDR_W-1:0] cmd_addr,
  input  logic [NCH*LEN_W-1:0]  cmd_len,
  output logic                  cmd_done,
  output logic [CH_W-1:0]       cmd_done_ch,
  output logic                  phy_start,
  output logic                  phy_dir,
  output logic [ADDR_W-1:0]     phy_addr,
  output logic [LEN_W-1:0]      phy_len,
  input  logic                  phy_done,
  input  logic                  phy_rd_valid,
  input  logic [DATA_W-1:0]     phy_rd_data,
  output logic                  rd_fifo_wen,
  output logic [DATA_W-1:0]     rd_fifo_wdata,
  input  logic                  rd_fifo_full,
  input  logic [DATA_W-1:0]     wr_fifo_rdata,
  input  logic                  wr_fifo_empty,
  output logic                  wr_fifo_ren,
  output logic                  phy_wr_valid,
  output logic [DATA_W-1:0]     phy_wr_data,
  input  logic                  phy_wr_ready,
  output logic                  mem_error,
  output logic [1:0]            err_code,
  input  logic                  err_clr
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_NEXT} state_t;

  state_t             state_q, state_d;
  logic [CH_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic               dir_q, dir_d;
  logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]   remain_q, remain_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [LEN_W-1:0]   sub_len_q, sub_len_d;
  logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               done_seen_q, done_seen_d;
  logic [15:0]        wdog_q, wdog_d;
  logic               mem_error_q, mem_error_d;
  logic [1:0]         err_code_q, err_code_d;
  logic               phy_start_q, phy_start_d;
  logic               phy_dir_q, phy_dir_d;
  logic [ADDR_W-1:0]  phy_addr_q, phy_addr_d;
  logic [LEN_W-1:0]   phy_len_q, phy_len_d;
  logic               cmd_done_q, cmd_done_d;
  logic [CH_W-1:0]    cmd_done_ch_q, cmd_done_ch_d;

  logic               grant_vld;
  logic [CH_W-1:0]    grant_ch;
  logic [ADDR_W-1:0]  sel_addr;
  logic [LEN_W-1:0]   sel_len;
  logic               in_xfer, rd_hit, room, beat, activity, done_any;
  logic [LEN_W-1:0]   cnt_next, remain_nx;
  logic [ADDR_W-1:0]  addr_nx;
  logic               err_proto, err_ovf, err_tmo, err_any;
  logic [1:0]         err_val;

  function automatic logic [LEN_W-1:0] clip(input logic [LEN_W-1:0] n);
    return (n > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : n;
  endfunction

  // Scan downward so the lowest offset from rr_ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (cmd_valid[(int'(rr_ptr_q) + k) % NCH]) begin
        grant_vld = 1'b1;
        grant_ch  = CH_W'((int'(rr_ptr_q) + k) % NCH);
      end
    end
  end

  always_comb begin
    cmd_ready = '0;
    if (state_q == S_IDLE && grant_vld) cmd_ready[grant_ch] = 1'b1;
  end

  assign sel_addr = cmd_addr[grant_ch*ADDR_W +: ADDR_W];
  assign sel_len  = cmd_len[grant_ch*LEN_W +: LEN_W];

  assign in_xfer       = (state_q == S_XFER);
  assign room          = (beat_cnt_q < sub_len_q);
  assign rd_hit        = in_xfer && !dir_q && phy_rd_valid;
  assign rd_fifo_wen   = rd_hit && room && !rd_fifo_full;
  assign rd_fifo_wdata = rd_fifo_wen ? phy_rd_data : '0;
  assign phy_wr_valid  = in_xfer && dir_q && !wr_fifo_empty && room;
  assign wr_fifo_ren   = phy_wr_valid && phy_wr_ready;
  assign phy_wr_data   = phy_wr_valid ? wr_fifo_rdata : '0;

  assign beat     = rd_fifo_wen || wr_fifo_ren;
  assign activity = rd_hit || wr_fifo_ren || phy_done;
  assign cnt_next = beat_cnt_q + {{(LEN_W-1){1'b0}}, beat};
  assign done_any = done_seen_q || phy_done;

  // Dropped overflow beats still count as activity for the watchdog.
  assign err_proto = in_xfer && ((rd_hit && !room) || (phy_done && (cnt_next < sub_len_q)));
  assign err_ovf   = rd_hit && room && rd_fifo_full;
  assign err_tmo   = in_xfer && !activity && ((wdog_q + 16'd1) == 16'(TIMEOUT));
  assign err_any   = err_proto || err_ovf || err_tmo;
  assign err_val   = err_proto ? 2'd3 : (err_ovf ? 2'd2 : 2'd1);

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    dir_d         = dir_q;
    cur_addr_d    = cur_addr_q;
    remain_d      = remain_q;
    ch_d          = ch_q;
    sub_len_d     = sub_len_q;
    beat_cnt_d    = beat_cnt_q;
    done_seen_d   = done_seen_q;
    wdog_d        = wdog_q;
    mem_error_d   = mem_error_q;
    err_code_d    = err_code_q;
    phy_start_d   = 1'b0;
    phy_dir_d     = 1'b0;
    phy_addr_d    = '0;
    phy_len_d     = '0;
    cmd_done_d    = 1'b0;
    cmd_done_ch_d = '0;
    remain_nx     = remain_q - sub_len_q;
    addr_nx       = cur_addr_q + ADDR_W'(sub_len_q) * ADDR_W'(BEAT_BYTES);

    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          dir_d      = cmd_wr[grant_ch];
          cur_addr_d = sel_addr;
          remain_d   = sel_len;
          ch_d       = grant_ch;
          rr_ptr_d   = CH_W'((int'(grant_ch) + 1) % NCH);
          if (sel_len == '0) begin
            sub_len_d     = '0;
            state_d       = S_NEXT;
            cmd_done_d    = 1'b1;
            cmd_done_ch_d = grant_ch;
          end else begin
            sub_len_d   = clip(sel_len);
            state_d     = S_SETUP;
            phy_start_d = 1'b1;
            phy_dir_d   = cmd_wr[grant_ch];
            phy_addr_d  = sel_addr;
            phy_len_d   = clip(sel_len);
          end
        end
      end
      S_SETUP: begin
        beat_cnt_d  = '0;
        done_seen_d = 1'b0;
        wdog_d      = '0;
        state_d     = S_XFER;
      end
      S_XFER: begin
        beat_cnt_d  = cnt_next;
        done_seen_d = done_any;
        wdog_d      = activity ? 16'd0 : wdog_q + 16'd1;
        if (err_any) begin
          state_d       = S_IDLE;
          cmd_done_d    = 1'b1;
          cmd_done_ch_d = ch_q;
        end else if ((cnt_next == sub_len_q) && done_any) begin
          state_d = S_NEXT;
          if (remain_q == sub_len_q) begin
            cmd_done_d    = 1'b1;
            cmd_done_ch_d = ch_q;
          end
        end
      end
      S_NEXT: begin
        remain_d   = remain_nx;
        cur_addr_d = addr_nx;
        if (remain_nx == '0) begin
          state_d = S_IDLE;
        end else begin
          sub_len_d   = clip(remain_nx);
          state_d     = S_SETUP;
          phy_start_d = 1'b1;
          phy_dir_d   = dir_q;
          phy_addr_d  = addr_nx;
          phy_len_d   = clip(remain_nx);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // First error is kept; a new error in the clear cycle replaces it.
    if (err_any) begin
      mem_error_d = 1'b1;
      if (!mem_error_q || err_clr) err_code_d = err_val;
    end else if (err_clr) begin
      mem_error_d = 1'b0;
      err_code_d  = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      dir_q         <= 1'b0;
      cur_addr_q    <= '0;
      remain_q      <= '0;
      ch_q          <= '0;
      sub_len_q     <= '0;
      beat_cnt_q    <= '0;
      done_seen_q   <= 1'b0;
      wdog_q        <= '0;
      mem_error_q   <= 1'b0;
      err_code_q    <= 2'd0;
      phy_start_q   <= 1'b0;
      phy_dir_q     <= 1'b0;
      phy_addr_q    <= '0;
      phy_len_q     <= '0;
      cmd_done_q    <= 1'b0;
      cmd_done_ch_q <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      dir_q         <= dir_d;
      cur_addr_q    <= cur_addr_d;
      remain_q      <= remain_d;
      ch_q          <= ch_d;
      sub_len_q     <= sub_len_d;
      beat_cnt_q    <= beat_cnt_d;
      done_seen_q   <= done_seen_d;
      wdog_q        <= wdog_d;
      mem_error_q   <= mem_error_d;
      err_code_q    <= err_code_d;
      phy_start_q   <= phy_start_d;
      phy_dir_q     <= phy_dir_d;
      phy_addr_q    <= phy_addr_d;
      phy_len_q     <= phy_len_d;
      cmd_done_q    <= cmd_done_d;
      cmd_done_ch_q <= cmd_done_ch_d;
    end
  end

  assign phy_start   = phy_start_q;
  assign phy_dir     = phy_dir_q;
  assign phy_addr    = phy_addr_q;
  assign phy_len     = phy_len_q;
  assign cmd_done    = cmd_done_q;
  assign cmd_done_ch = cmd_done_ch_q;
  assign mem_error   = mem_error_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_ai_mc_burst_sched.sv
// Randomized bench for ai_mc_burst_sched: a reactive PHY/FIFO model drives
// commands and checks bursts, beats, timing and errors against a simple model.
module tb_ai_mc_burst_sched;
  localparam int NCH        = 2;
  localparam int ADDR_W     = 32;
  localparam int LEN_W      = 16;
  localparam int DATA_W     = 32;
  localparam int MAX_BURST  = 16;
  localparam int TIMEOUT    = 20;
  localparam int CH_W       = 1;
  localparam int BEAT_BYTES = DATA_W / 8;
  localparam int BUDGET     = 1500;

  logic                  clk, rst;
  logic [NCH-1:0]        cmd_valid, cmd_ready, cmd_wr;
  logic [NCH*ADDR_W-1:0] cmd_addr;
  logic [NCH*LEN_W-1:0]  cmd_len;
  logic                  cmd_done;
  logic [CH_W-1:0]       cmd_done_ch;
  logic                  phy_start, phy_dir;
  logic [ADDR_W-1:0]     phy_addr;
  logic [LEN_W-1:0]      phy_len;
  logic                  phy_done, phy_rd_valid;
  logic [DATA_W-1:0]     phy_rd_data;
  logic                  rd_fifo_wen, rd_fifo_full;
  logic [DATA_W-1:0]     rd_fifo_wdata, wr_fifo_rdata, phy_wr_data;
  logic                  wr_fifo_empty, wr_fifo_ren, phy_wr_valid, phy_wr_ready;
  logic                  mem_error, err_clr;
  logic [1:0]            err_code;

  int n_chk = 0;
  int n_err = 0;
  int rr_m  = 0;

  ai_mc_burst_sched #(
    .NCH(NCH), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W),
    .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_done(cmd_done), .cmd_done_ch(cmd_done_ch),
    .phy_start(phy_start), .phy_dir(phy_dir), .phy_addr(phy_addr), .phy_len(phy_len),
    .phy_done(phy_done), .phy_rd_valid(phy_rd_valid), .phy_rd_data(phy_rd_data),
    .rd_fifo_wen(rd_fifo_wen), .rd_fifo_wdata(rd_fifo_wdata), .rd_fifo_full(rd_fifo_full),
    .wr_fifo_rdata(wr_fifo_rdata), .wr_fifo_empty(wr_fifo_empty), .wr_fifo_ren(wr_fifo_ren),
    .phy_wr_valid(phy_wr_valid), .phy_wr_data(phy_wr_data), .phy_wr_ready(phy_wr_ready),
    .mem_error(mem_error), .err_code(err_code), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    cmd_valid     = '0;
    cmd_wr        = '0;
    cmd_addr      = '0;
    cmd_len       = '0;
    phy_done      = 1'b0;
    phy_rd_valid  = 1'b0;
    phy_rd_data   = '0;
    rd_fifo_full  = 1'b0;
    wr_fifo_rdata = '0;
    wr_fifo_empty = 1'b1;
    phy_wr_ready  = 1'b0;
    err_clr       = 1'b0;
  endtask

  // One error-free command; PHY side reacts with random gaps and stalls.
  task automatic run_cmd(input int ch, input bit wr, input logic [ADDR_W-1:0] addr, input int len);
    logic [ADDR_W-1:0] ea[$];
    int                el[$];
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d, wdata_m;
    int                rem, s, k, last_e, nxt_start, beats_left, total, idle;
    bit                active, fin, xfer;
    a = addr;
    rem = len;
    while (rem > 0) begin
      s = (rem > MAX_BURST) ? MAX_BURST : rem;
      ea.push_back(a);
      el.push_back(s);
      a = a + ADDR_W'(s * BEAT_BYTES);
      rem -= s;
    end
    @(posedge clk); #1;
    set_idle();
    cmd_valid[ch] = 1'b1;
    cmd_wr[ch] = wr;
    cmd_addr[ch*ADDR_W +: ADDR_W] = addr;
    cmd_len[ch*LEN_W +: LEN_W] = LEN_W'(len);
    #1;
    chk("cmd_ready", cmd_ready, 64'd1 << ch);
    rr_m = (ch + 1) % NCH;
    active = 0; fin = 0; total = 0; last_e = 0; nxt_start = 1;
    beats_left = 0; idle = 0; wdata_m = $urandom;
    for (k = 1; k <= BUDGET && !fin; k++) begin
      @(posedge clk); #1;
      set_idle();
      if (phy_start) begin
        chk("start_cyc", k, nxt_start);
        chk("start_pending", ea.size() > 0, 1);
        if (ea.size() > 0) begin
          chk("phy_addr", phy_addr, ea[0]);
          chk("phy_len", phy_len, el[0]);
          chk("phy_dir", phy_dir, wr);
          beats_left = el[0];
          void'(ea.pop_front());
          void'(el.pop_front());
          active = 1; idle = 0;
        end
      end
      if (cmd_done) begin
        chk("done_cyc", k, last_e + 1);
        chk("done_ch", cmd_done_ch, ch);
        chk("beat_total", total, len);
        chk("bursts_left", ea.size(), 0);
        chk("no_error", mem_error, 0);
        fin = 1;
      end else if (active && k >= nxt_start + 1) begin
        idle++;
        if (!wr) begin
          if (beats_left > 0 && ($urandom_range(0, 9) < 6 || idle > 8)) begin
            d = $urandom;
            phy_rd_valid = 1'b1;
            phy_rd_data = d;
          end
          #1;
          chk("rd_wen", rd_fifo_wen, phy_rd_valid);
          if (phy_rd_valid) begin
            chk("rd_data", rd_fifo_wdata, d);
            beats_left--; total++; idle = 0;
          end
        end else begin
          wr_fifo_empty = ($urandom_range(0, 9) < 3) && (idle <= 8);
          phy_wr_ready  = ($urandom_range(0, 9) < 7) || (idle > 8);
          wr_fifo_rdata = wdata_m;
          xfer = (beats_left > 0) && !wr_fifo_empty && phy_wr_ready;
          #1;
          chk("wr_valid", phy_wr_valid, (beats_left > 0) && !wr_fifo_empty);
          chk("wr_ren", wr_fifo_ren, xfer);
          if (xfer) begin
            chk("wr_data", phy_wr_data, wdata_m);
            wdata_m = $urandom;
            beats_left--; total++; idle = 0;
          end
        end
        if (beats_left == 0 && ($urandom_range(0, 1) == 1 || idle > 8)) begin
          phy_done = 1'b1;
          active = 0;
          last_e = k;
          nxt_start = k + 2;
        end
      end
    end
    chk("cmd_finished", fin, 1);
    set_idle();
  endtask

  // Read of 4 beats on channel 0 that ends in an error.
  // mode 0 silent PHY, 1 full FIFO on 2nd beat, 2 done after 3 beats, 3 fifth beat.
  task automatic run_err(input int mode, input logic [1:0] exp_code);
    int k, n, err_k;
    bit fin;
    n = 0; fin = 0;
    err_k = (mode == 0) ? TIMEOUT + 1 : -1;
    @(posedge clk); #1;
    set_idle();
    cmd_valid[0] = 1'b1;
    cmd_addr[ADDR_W-1:0] = $urandom;
    cmd_len[LEN_W-1:0] = 4;
    rr_m = 1 % NCH;
    for (k = 1; k <= TIMEOUT + 10 && !fin; k++) begin
      @(posedge clk); #1;
      set_idle();
      if (cmd_done) begin
        chk("err_done_cyc", k, err_k + 1);
        chk("err_ch", cmd_done_ch, 0);
        chk("err_flag", mem_error, 1);
        chk("err_code", err_code, exp_code);
        fin = 1;
      end else if (k >= 2 && err_k < 0) begin
        phy_rd_valid = 1'b1;
        phy_rd_data = $urandom;
        if (mode == 1 && n == 1) begin
          rd_fifo_full = 1'b1;
          err_k = k;
        end else if (mode == 2 && n == 3) begin
          phy_rd_valid = 1'b0;
          phy_done = 1'b1;
          err_k = k;
        end else if (mode == 3 && n == 4) begin
          err_k = k;
        end
        n++;
        #1;
        if (mode == 1 && err_k == k) chk("ovf_no_wen", rd_fifo_wen, 0);
      end
    end
    chk("err_finished", fin, 1);
    set_idle();
  endtask

  task automatic clr_err();
    @(posedge clk); #1;
    chk("err_sticky", mem_error, 1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("clr_flag", mem_error, 0);
    chk("clr_code", err_code, 0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_start"}, phy_start, 0);
    chk({tag, "_done"}, cmd_done, 0);
    chk({tag, "_ready"}, cmd_ready, 0);
    chk({tag, "_wr_valid"}, phy_wr_valid, 0);
    chk({tag, "_ren"}, wr_fifo_ren, 0);
    chk({tag, "_wen"}, rd_fifo_wen, 0);
    chk({tag, "_addr"}, phy_addr, 0);
    chk({tag, "_len"}, phy_len, 0);
    chk({tag, "_err"}, mem_error, 0);
    chk({tag, "_code"}, err_code, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, errors so far %0d", n_err);
    $fatal(1, "time limit");
  end

  initial begin
    int strobes, g, exp_rdy, done_ch_exp;
    bit idle_m, done_exp;
    logic [NCH-1:0] v;
    logic [ADDR_W-1:0] a;
    int l;

    set_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_quiet("reset");

    run_cmd(0, 1'b0, 32'h100, 5);
    run_cmd(1, 1'b1, 32'h0, 40);
    run_cmd(0, 1'b0, 32'h40, 0);
    run_cmd(1, 1'b1, 32'hFFFF_FFE0, 20);
    for (int i = 0; i < 12; i++) begin
      a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF00 | ($urandom & 32'hFC)) : ($urandom & 32'hFFFF_FFFC);
      l = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 50);
      run_cmd($urandom_range(0, NCH - 1), 1'($urandom_range(0, 1)), a, l);
    end

    run_err(0, 2'd1);
    clr_err();
    run_err(1, 2'd2);
    clr_err();
    run_err(2, 2'd3);
    run_err(1, 2'd3);
    clr_err();
    run_err(3, 2'd3);
    clr_err();

    // reset in the middle of a write burst
    @(posedge clk); #1;
    set_idle();
    cmd_valid[0] = 1'b1;
    cmd_wr[0] = 1'b1;
    cmd_len[LEN_W-1:0] = 8;
    cmd_addr[ADDR_W-1:0] = 32'h2000;
    repeat (3) begin
      @(posedge clk); #1;
      set_idle();
      wr_fifo_empty = 1'b0;
      phy_wr_ready = 1'b1;
      wr_fifo_rdata = $urandom;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk_quiet("mid_rst");
    rst = 1'b0;
    rr_m = 0;
    strobes = 0;
    repeat (6) begin
      @(posedge clk); #1;
      strobes += int'(cmd_done) + int'(phy_start) + int'(phy_wr_valid);
    end
    chk("post_rst_quiet", strobes, 0);
    set_idle();

    // arbitration: zero-length commands, both channels then random valids
    idle_m = 1; done_exp = 0; done_ch_exp = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      chk("arb_done", cmd_done, done_exp);
      if (done_exp) chk("arb_done_ch", cmd_done_ch, done_ch_exp);
      v = (c < 10) ? {NCH{1'b1}} : NCH'($urandom);
      set_idle();
      cmd_valid = v;
      cmd_wr = NCH'($urandom);
      #1;
      exp_rdy = 0; g = 0;
      if (idle_m && v != '0) begin
        for (int k = NCH - 1; k >= 0; k--)
          if (v[(rr_m + k) % NCH]) g = (rr_m + k) % NCH;
        exp_rdy = 1 << g;
      end
      chk("arb_ready", cmd_ready, exp_rdy);
      done_exp = (exp_rdy != 0);
      done_ch_exp = g;
      if (exp_rdy != 0) rr_m = (g + 1) % NCH;
      idle_m = (exp_rdy == 0);
    end
    set_idle();
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
